// File: rtl/risk_report_tx.sv
// risk_report_tx: classifies incoming risk samples into low/mid/high bands,
// drives a hysteretic confirmed alarm, and serialises each accepted sample
// as an 8N1 UART frame (start 0, 8 data bits LSB first, stop 1).
//
// Handshake: risk_valid is a single-cycle strobe with no back-pressure.
// A strobe seen while busy=0 starts a frame. A strobe seen while busy=1
// cannot be sent; it sets the sticky overrun flag instead. Every strobe,
// sent or dropped, still updates level and the alarm counter.
module risk_report_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int HI_THRESH    = 70,
  parameter int LO_THRESH    = 40,
  parameter int CONFIRM      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] risk,
  input  logic       risk_valid,
  output logic       tx,
  output logic       busy,
  output logic       alarm,
  output logic [1:0] level,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_next;
  logic [7:0]  timer, timer_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shreg, shreg_next;
  logic        tx_next, busy_next;
  logic [3:0]  confirm_cnt;

  logic [7:0]  sample;
  logic        bit_end;
  logic        is_high, is_low;

  // Values above the nominal 0..100 range are treated as 100 everywhere.
  assign sample  = (risk > 8'd100) ? 8'd100 : risk;
  assign is_high = (sample >= 8'(HI_THRESH));
  assign is_low  = (sample <= 8'(LO_THRESH));
  assign bit_end = (timer == 8'(CLKS_PER_BIT - 1));

  // Frame state register plus registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= 8'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      tx      <= tx_next;
      busy    <= busy_next;
    end
  end

  // Next-state logic; tx/busy are computed one edge early so they register
  // in step with the state they belong to.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    tx_next      = tx;
    busy_next    = busy;
    case (state)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (risk_valid) begin
          state_next   = START;
          timer_next   = 8'd0;
          bit_idx_next = 3'd0;
          shreg_next   = sample;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          timer_next = 8'd0;
          tx_next    = shreg[0];
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_next = 8'd0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = shreg >> 1;
            tx_next      = shreg[1];
          end
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          timer_next = 8'd0;
          busy_next  = 1'b0;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Band classification and confirmed-alarm hysteresis on every strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= 2'd0;
      alarm       <= 1'b0;
      confirm_cnt <= 4'd0;
    end else if (risk_valid) begin
      level <= is_high ? 2'd2 : (is_low ? 2'd0 : 2'd1);
      if ((!alarm && is_high) || (alarm && is_low)) begin
        if (confirm_cnt >= 4'(CONFIRM - 1)) begin
          alarm       <= ~alarm;
          confirm_cnt <= 4'd0;
        end else begin
          confirm_cnt <= confirm_cnt + 4'd1;
        end
      end else begin
        confirm_cnt <= 4'd0;
      end
    end
  end

  // Sticky overrun: a sample arrived while a frame was still on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (risk_valid && busy) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_risk_report_tx.sv
// Directed + randomized bench for risk_report_tx with CLKS_PER_BIT=4,
// CONFIRM=4. A behavioural model tracks level/alarm/overrun and an expected
// queue holds the tx bit for every cycle of the frame in flight.
module tb_risk_report_tx;

  localparam int CPB = 4;
  localparam int CNF = 4;
  localparam int HI  = 70;
  localparam int LO  = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] risk;
  logic       risk_valid;
  logic       tx, busy, alarm, overrun;
  logic [1:0] level;

  int n_checks;
  int n_err;

  logic [0:0] exp_q[$];
  int         hist[$];
  logic [1:0] exp_level;
  logic       exp_alarm;
  logic       exp_overrun;

  risk_report_tx #(
    .CLKS_PER_BIT(CPB),
    .HI_THRESH(HI),
    .LO_THRESH(LO),
    .CONFIRM(CNF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .risk(risk),
    .risk_valid(risk_valid),
    .tx(tx),
    .busy(busy),
    .alarm(alarm),
    .level(level),
    .overrun(overrun)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: band from clamped value; alarm toggles once the last
  // CNF samples since the previous toggle all sit in the opposite band.
  task automatic model_sample(input int v);
    int c;
    int want;
    bool_check: begin
      bit all_match;
      c = (v > 100) ? 100 : v;
      exp_level = (c >= HI) ? 2'd2 : ((c <= LO) ? 2'd0 : 2'd1);
      hist.push_back(int'(exp_level));
      want = exp_alarm ? 0 : 2;
      all_match = (hist.size() >= CNF);
      if (all_match) begin
        for (int k = hist.size() - CNF; k < hist.size(); k++)
          if (hist[k] != want) all_match = 1'b0;
      end
      if (all_match) begin
        exp_alarm = ~exp_alarm;
        hist.delete();
      end
    end
  endtask

  task automatic push_frame(input int v);
    int c;
    logic [7:0] b;
    c = (v > 100) ? 100 : v;
    b = 8'(c);
    for (int i = 0; i < 10 * CPB; i++) begin
      int bi;
      bi = i / CPB;
      if (bi == 0)      exp_q.push_back(1'b0);
      else if (bi == 9) exp_q.push_back(1'b1);
      else              exp_q.push_back(b[bi-1]);
    end
  endtask

  // Send one sample from idle, follow the whole frame cycle by cycle, and
  // optionally inject a second strobe at frame cycle inj_at (1..39).
  task automatic run_frame(input int v, input int inj_at, input int inj_v);
    logic [0:0] e;
    push_frame(v);
    risk = 8'(v);
    risk_valid = 1'b1;
    step();
    risk_valid = 1'b0;
    model_sample(v);
    chk("level", {6'd0, level}, {6'd0, exp_level});
    chk("alarm", {7'd0, alarm}, {7'd0, exp_alarm});
    chk("busy_start", {7'd0, busy}, 8'd1);
    e = exp_q.pop_front();
    chk("tx_bit0", {7'd0, tx}, {7'd0, e});
    for (int i = 1; i < 10 * CPB; i++) begin
      if (i == inj_at) begin
        risk = 8'(inj_v);
        risk_valid = 1'b1;
      end
      step();
      risk_valid = 1'b0;
      if (i == inj_at) begin
        model_sample(inj_v);
        exp_overrun = 1'b1;
        chk("level_drop", {6'd0, level}, {6'd0, exp_level});
        chk("alarm_drop", {7'd0, alarm}, {7'd0, exp_alarm});
        chk("overrun_set", {7'd0, overrun}, 8'd1);
      end
      e = exp_q.pop_front();
      chk($sformatf("tx_cyc%0d", i), {7'd0, tx}, {7'd0, e});
      if (i == 10 * CPB - 1) chk("busy_last", {7'd0, busy}, 8'd1);
    end
    step();
    chk("busy_end", {7'd0, busy}, 8'd0);
    chk("tx_idle", {7'd0, tx}, 8'd1);
    chk("overrun", {7'd0, overrun}, {7'd0, exp_overrun});
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_tx"}, {7'd0, tx}, 8'd1);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_alarm"}, {7'd0, alarm}, 8'd0);
    chk({tag, "_level"}, {6'd0, level}, 8'd0);
    chk({tag, "_overrun"}, {7'd0, overrun}, 8'd0);
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    exp_level = 2'd0;
    exp_alarm = 1'b0;
    exp_overrun = 1'b0;
    rst_n = 1'b0;
    risk = 8'd0;
    risk_valid = 1'b0;
    repeat (3) step();
    reset_checks("por");
    rst_n = 1'b1;
    step();
    reset_checks("idle");

    // Threshold boundaries and clamp.
    run_frame(40, -1, 0);
    chk("lvl40", {6'd0, level}, 8'd0);
    run_frame(70, -1, 0);
    chk("lvl70", {6'd0, level}, 8'd2);
    run_frame(41, -1, 0);
    chk("lvl41", {6'd0, level}, 8'd1);
    run_frame(8'h5A, -1, 0);
    run_frame(200, -1, 0);
    chk("lvl200", {6'd0, level}, 8'd2);

    // Dropped strobe mid-frame, then a clean back-to-back frame.
    run_frame(8'h33, 17, 8'h99);
    run_frame(8'h0F, -1, 0);
    chk("overrun_held", {7'd0, overrun}, 8'd1);

    // Alarm hysteresis: broken run, then confirmed rise, then confirmed fall.
    begin
      int seq_up[8] = '{80, 80, 80, 50, 80, 80, 80, 80};
      for (int k = 0; k < 8; k++) begin
        run_frame(seq_up[k], -1, 0);
        chk($sformatf("alarm_up%0d", k), {7'd0, alarm}, (k == 7) ? 8'd1 : 8'd0);
      end
      for (int k = 0; k < 4; k++) begin
        run_frame(30, -1, 0);
        chk($sformatf("alarm_dn%0d", k), {7'd0, alarm}, (k == 3) ? 8'd0 : 8'd1);
      end
      for (int k = 0; k < 4; k++) run_frame(90, -1, 0);
      chk("alarm_reraised", {7'd0, alarm}, 8'd1);
    end

    // Reset in the middle of the data bits aborts the frame immediately.
    risk = 8'hC3;
    risk_valid = 1'b1;
    step();
    risk_valid = 1'b0;
    repeat (14) step();
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    exp_q.delete();
    hist.delete();
    exp_level = 2'd0;
    exp_alarm = 1'b0;
    exp_overrun = 1'b0;
    step();
    reset_checks("rst_hold");
    rst_n = 1'b1;
    step();
    run_frame(8'h5A, -1, 0);

    // Randomized frames with occasional dropped strobes.
    for (int r = 0; r < 10; r++) begin
      int v, inj, iv;
      v = $urandom_range(0, 255);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10 * CPB - 1) : -1;
      iv = $urandom_range(0, 255);
      run_frame(v, inj, iv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/risk_report_tx.md
RISK_REPORT_TX -- requirements
Module: risk_report_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..255).
REQ-002 SHALL have parameter HI_THRESH, default 70, risk level at or above which a sample counts as high.
REQ-003 SHALL have parameter LO_THRESH, default 40, risk level at or below which a sample counts as low (LO_THRESH < HI_THRESH).
REQ-004 SHALL have parameter CONFIRM, default 4, number of consecutive qualifying samples needed to change alarm (1..15).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 risk  input  8  risk value from the fuzzy estimator, nominal range 0..100.
REQ-008 risk_valid  input  1  single-cycle strobe: risk is a new sample.
REQ-009 tx  output  1  UART-style serial line, idle high.
REQ-010 busy  output  1  high while a frame is in flight.
REQ-011 alarm  output  1  hysteretic, confirmed high-risk alarm.
REQ-012 level  output  2  band of the last accepted sample: 0 low, 1 mid, 2 high.
REQ-013 overrun  output  1  sticky flag: a sample arrived while busy.

Function
REQ-014 SHALL clamp any risk > 100 to 100 before band classification, alarm counting and transmission.
REQ-015 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE; one bit-timer counts 0..CLKS_PER_BIT-1 per bit.
REQ-016 SHALL, in IDLE with risk_valid high at edge N, latch the clamped byte and enter START; from edge N, tx=0 and busy=1 (registered outputs).
REQ-017 SHALL hold each bit exactly CLKS_PER_BIT cycles: start bit 0, 8 data bits LSB first, stop bit 1; the frame is 10*CLKS_PER_BIT cycles.
REQ-018 SHALL return to IDLE with busy=0 at the edge that ends the stop bit.
REQ-019 SHALL accept a new frame on the first edge at which busy is 0 (back-to-back frames have no extra idle gap).
REQ-020 SHALL, on risk_valid while busy=1, not alter the in-flight frame, set overrun=1 and keep it set until reset.
REQ-021 SHALL update level and alarm counting on every risk_valid, including dropped samples: band 2 if value >= HI_THRESH, 0 if value <= LO_THRESH, else 1.
REQ-022 SHALL, while alarm=0, count consecutive high samples; alarm rises on the edge registering the CONFIRM-th. Any non-high sample clears the count.
REQ-023 SHALL, while alarm=1, count consecutive low samples; alarm falls on the edge registering the CONFIRM-th. Any non-low sample clears the count.
REQ-024 SHALL clear the confirm counter whenever alarm toggles, and saturate it at CONFIRM.
REQ-025 SHALL leave level, alarm and counters unchanged on cycles without risk_valid.

Reset
REQ-026 SHALL, while rst_n=0, force tx=1, busy=0, alarm=0, level=0, overrun=0, FSM=IDLE, counters=0, asynchronously.
REQ-027 SHALL abort any in-flight frame on reset; tx goes high immediately with no partial stop bit.
REQ-028 SHALL ignore risk_valid sampled on the first edge after rst_n deasserts only if rst_n is still low at that edge; otherwise the sample is accepted normally.

Verification
REQ-029 CLKS_PER_BIT=4, risk=0x5A strobe in IDLE -> tx 40 cycles: 0x4 (0), then 0,1,0,1,1,0,1,0 x4 each, then 1x4; busy high exactly 40 cycles.
REQ-030 risk=200 strobe -> transmitted byte 0x64, level=2.
REQ-031 strobe during frame -> frame bits unchanged, overrun=1 and held; next strobe after busy=0 starts a new frame.
REQ-032 CONFIRM=4: samples 80,80,80,50,80,80,80,80 -> alarm rises only on 8th sample; then 30,30,30,30 -> alarm falls on 4th.
REQ-033 rst_n pulsed low mid-DATA -> tx=1, busy=0, alarm=0, overrun=0 within the reset cycle; next strobe sends a full clean frame.
REQ-034 risk=40 and risk=70 strobes -> level 0 and 2 respectively (threshold equality boundaries); risk=41 -> level 1.
